// File: rtl/fcmp_pkg.sv
// Shared types for the compare scheduler: op encodings, FSM states and the
// latched request record.
package fcmp_pkg;

    // Compare operations; encodings 5..7 are illegal and still take one pass.
    typedef enum logic [2:0] {
        FLT  = 3'd0,
        FLE  = 3'd1,
        FEQ  = 3'd2,
        FMIN = 3'd3,
        FMAX = 3'd4
    } fcmp_op_e;

    // Scheduler states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP1 = 2'd1,
        CMP2 = 2'd2,
        RESP = 2'd3
    } fcmp_state_e;

    // One request as captured on acceptance.
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] x1;
        logic [31:0] x2;
    } fcmp_req_t;

    // True for the encodings that map onto a real operation.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= 3'd4);
    endfunction

endpackage

// File: rtl/fclt.sv
// Single-precision less-than comparator. Two operands whose exponent
// fields are both zero compare equal (covers +0/-0 and denormals).
// NaNs are not treated specially.
module fclt (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        lt
);

    logic sa;
    logic sb;
    logic both_zero_exp;
    logic mag_gt;
    logic mag_lt;

    assign sa            = a[31];
    assign sb            = b[31];
    assign both_zero_exp = (a[30:23] == 8'd0) && (b[30:23] == 8'd0);
    assign mag_gt        = (a[30:0] > b[30:0]);
    assign mag_lt        = (a[30:0] < b[30:0]);

    // Sign-magnitude ordering: negative below positive, larger magnitude
    // is smaller when both are negative.
    always_comb begin
        if (both_zero_exp) begin
            lt = 1'b0;
        end else begin
            lt = (sa & ~sb) | (sa & sb & mag_gt) | (~sa & ~sb & mag_lt);
        end
    end

endmodule

// File: rtl/fcmp_sched.sv
// Round-robin scheduler sharing one fclt comparator between NREQ issue
// ports. FEQ runs two passes (x1<x2 then x2<x1); every other op runs one.
// The result sits in a single registered response slot until consumed.
module fcmp_sched
    import fcmp_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*3-1:0]  req_op,
    input  logic [NREQ*32-1:0] req_x1,
    input  logic [NREQ*32-1:0] req_x2,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [31:0]        resp_data,
    output logic [IDW-1:0]     resp_id,
    output logic               resp_illegal,
    output logic               busy
);

    // Pick the first valid requester after 'last', wrapping; 'last' itself
    // has the lowest priority. MSB of the result flags that one was found.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  last);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (valid[idx]) begin
                res = {1'b1, IDW'(idx)};
            end
        end
        return res;
    endfunction

    fcmp_state_e    state_reg;
    fcmp_state_e    state_next;
    logic [IDW-1:0] last_grant_reg;
    fcmp_req_t      req_reg;
    logic [IDW-1:0] id_reg;
    logic           pass1_reg;
    logic [31:0]    resp_data_reg;
    logic [IDW-1:0] resp_id_reg;
    logic           resp_illegal_reg;

    fcmp_req_t      req_vec [NREQ];
    logic [IDW:0]   pick;
    logic [IDW-1:0] grant_idx;
    logic           grant_take;

    logic           cmp_swap;
    logic [31:0]    cmp_a;
    logic [31:0]    cmp_b;
    logic           cmp_lt;
    logic [31:0]    result_data;
    logic           result_illegal;

    // Unpack the flat request buses into per-requester records.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_vec[gi].op = req_op[3*gi +: 3];
            assign req_vec[gi].x1 = req_x1[32*gi +: 32];
            assign req_vec[gi].x2 = req_x2[32*gi +: 32];
        end
    endgenerate

    assign pick      = rr_pick(req_valid, last_grant_reg);
    assign grant_idx = pick[IDW-1:0];

    // FEQ's second pass and FLE both need lt(x2, x1).
    assign cmp_swap = (state_reg == CMP2) || (req_reg.op == FLE);
    assign cmp_a    = cmp_swap ? req_reg.x2 : req_reg.x1;
    assign cmp_b    = cmp_swap ? req_reg.x1 : req_reg.x2;

    fclt u_fclt (
        .a  (cmp_a),
        .b  (cmp_b),
        .lt (cmp_lt)
    );

    // Next state, accept window and per-requester ready.
    always_comb begin
        state_next = state_reg;
        grant_take = 1'b0;
        req_ready  = '0;
        case (state_reg)
            IDLE: begin
                if (pick[IDW]) begin
                    grant_take = 1'b1;
                    state_next = CMP1;
                end
            end
            CMP1: begin
                state_next = (req_reg.op == FEQ) ? CMP2 : RESP;
            end
            CMP2: begin
                state_next = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    if (pick[IDW]) begin
                        grant_take = 1'b1;
                        state_next = CMP1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (grant_take) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Result formatting from the current comparator pass.
    always_comb begin
        result_data    = '0;
        result_illegal = 1'b0;
        if (!op_is_legal(req_reg.op)) begin
            result_illegal = 1'b1;
        end else begin
            case (req_reg.op)
                FLT:     result_data = {31'd0, cmp_lt};
                FLE:     result_data = {31'd0, ~cmp_lt};
                FEQ:     result_data = {31'd0, ~pass1_reg & ~cmp_lt};
                FMIN:    result_data = cmp_lt ? req_reg.x1 : req_reg.x2;
                FMAX:    result_data = cmp_lt ? req_reg.x2 : req_reg.x1;
                default: result_data = '0;
            endcase
        end
    end

    // State, request capture and response slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg        <= IDLE;
            last_grant_reg   <= IDW'(NREQ - 1);
            req_reg          <= '0;
            id_reg           <= '0;
            pass1_reg        <= 1'b0;
            resp_data_reg    <= '0;
            resp_id_reg      <= '0;
            resp_illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (grant_take) begin
                req_reg        <= req_vec[grant_idx];
                id_reg         <= grant_idx;
                last_grant_reg <= grant_idx;
            end
            if (state_reg == CMP1) begin
                if (req_reg.op == FEQ) begin
                    pass1_reg <= cmp_lt;
                end else begin
                    resp_data_reg    <= result_data;
                    resp_illegal_reg <= result_illegal;
                    resp_id_reg      <= id_reg;
                end
            end
            if (state_reg == CMP2) begin
                resp_data_reg    <= result_data;
                resp_illegal_reg <= 1'b0;
                resp_id_reg      <= id_reg;
            end
        end
    end

    assign resp_valid   = (state_reg == RESP);
    assign resp_data    = resp_data_reg;
    assign resp_id      = resp_id_reg;
    assign resp_illegal = resp_illegal_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_fcmp_sched.sv
// Directed bench for fcmp_sched: latency, op results, round-robin
// alternation, backpressure hold and reset during an in-flight FEQ.
module tb_fcmp_sched;
    import fcmp_pkg::*;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic               clk = 1'b0;
    logic               rstn;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*3-1:0]  req_op;
    logic [NREQ*32-1:0] req_x1;
    logic [NREQ*32-1:0] req_x2;
    logic               resp_valid;
    logic               resp_ready;
    logic [31:0]        resp_data;
    logic [IDW-1:0]     resp_id;
    logic               resp_illegal;
    logic               busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fcmp_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_x1       (req_x1),
        .req_x2       (req_x2),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_id      (resp_id),
        .resp_illegal (resp_illegal),
        .busy         (busy)
    );

    task automatic set_req(input int idx, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_op[3*idx +: 3]  = op;
        req_x1[32*idx +: 32] = a;
        req_x2[32*idx +: 32] = b;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = '0; resp_ready = 1'b1;
        req_op = '0; req_x1 = '0; req_x2 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (resp_data !== 32'd0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
        checks++; if (resp_id !== 1'b0) begin errors++; $display("FAIL reset_resp_id: got %h expected 0", resp_id); end
        checks++; if (resp_illegal !== 1'b0) begin errors++; $display("FAIL reset_resp_illegal: got %b expected 0", resp_illegal); end
        rstn = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL idle_no_req_ready: got %b expected 00", req_ready); end
        $display("test_reset done");
    endtask

    task automatic test_alternate();
        logic [1:0] exp_ready;
        logic       exp_valid;
        logic       exp_id;
        set_req(0, FLT, 32'hBF800000, 32'h3F800000);
        set_req(1, FLT, 32'h3F800000, 32'hBF800000);
        req_valid = 2'b11; resp_ready = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            exp_ready = (k % 2 == 0) ? (((k / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_valid = (k >= 2) && (k % 2 == 0);
            checks++; if ($countones(req_ready) > 1) begin errors++; $display("FAIL alt_ready_onehot k=%0d: got %b expected at most one bit", k, req_ready); end
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL alt_ready k=%0d: got %b expected %b", k, req_ready, exp_ready); end
            checks++; if (resp_valid !== exp_valid) begin errors++; $display("FAIL alt_resp_valid k=%0d: got %b expected %b", k, resp_valid, exp_valid); end
            if (exp_valid) begin
                exp_id = 1'(((k / 2) - 1) % 2);
                checks++; if (resp_id !== exp_id) begin errors++; $display("FAIL alt_resp_id k=%0d: got %h expected %h", k, resp_id, exp_id); end
                checks++; if (resp_data !== {31'd0, ~exp_id}) begin errors++; $display("FAIL alt_resp_data k=%0d: got %h expected %h", k, resp_data, {31'd0, ~exp_id}); end
            end
            $display("alt cycle %0d: req_ready=%b resp_valid=%b resp_id=%h resp_data=%h", k, req_ready, resp_valid, resp_id, resp_data);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_id !== 1'b0) begin errors++; $display("FAIL alt_last_resp: got valid=%b id=%h expected valid=1 id=0", resp_valid, resp_id); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL alt_drain_ready: got %b expected 00", req_ready); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL alt_back_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_single_ops();
        int          t_idx [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
        logic [2:0]  t_op  [9] = '{3'd0, 3'd2, 3'd2, 3'd3, 3'd4, 3'd1, 3'd6, 3'd0, 3'd0};
        logic [31:0] t_x1  [9] = '{32'hBF800000, 32'h00000000, 32'h3F800000, 32'h40000000, 32'h40000000,
                                   32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hC0000000};
        logic [31:0] t_x2  [9] = '{32'h3F800000, 32'h80000000, 32'h40000000, 32'h3F800000, 32'h3F800000,
                                   32'h3F800000, 32'h40000000, 32'hBF800000, 32'hBF800000};
        logic [31:0] t_exp [9] = '{32'd1, 32'd1, 32'd0, 32'h3F800000, 32'h40000000,
                                   32'd1, 32'd0, 32'd0, 32'd1};
        logic        t_ill [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  exp_ready;
        resp_ready = 1'b1;
        for (int n = 0; n < 9; n++) begin
            set_req(t_idx[n], t_op[n], t_x1[n], t_x2[n]);
            exp_ready = (t_idx[n] == 0) ? 2'b01 : 2'b10;
            req_valid = exp_ready;
            #1;
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL op%0d_accept: got %b expected %b", n, req_ready, exp_ready); end
            @(posedge clk); #1;
            req_valid = 2'b00;
            checks++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL op%0d_t1: got valid=%b busy=%b expected valid=0 busy=1", n, resp_valid, busy); end
            if (t_op[n] == 3'd2) begin
                @(posedge clk); #1;
                checks++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL op%0d_feq_t2: got valid=%b busy=%b expected valid=0 busy=1", n, resp_valid, busy); end
            end
            @(posedge clk); #1;
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL op%0d_resp_valid: got %b expected 1", n, resp_valid); end
            checks++; if (resp_data !== t_exp[n]) begin errors++; $display("FAIL op%0d_resp_data: got %h expected %h", n, resp_data, t_exp[n]); end
            checks++; if (resp_id !== 1'(t_idx[n])) begin errors++; $display("FAIL op%0d_resp_id: got %h expected %0d", n, resp_id, t_idx[n]); end
            checks++; if (resp_illegal !== t_ill[n]) begin errors++; $display("FAIL op%0d_resp_illegal: got %b expected %b", n, resp_illegal, t_ill[n]); end
            $display("op %0d: req%0d op=%0d x1=%h x2=%h -> data=%h illegal=%b", n, t_idx[n], t_op[n], t_x1[n], t_x2[n], resp_data, resp_illegal);
            @(posedge clk); #1;
            checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL op%0d_done: got valid=%b busy=%b expected 0 0", n, resp_valid, busy); end
        end
    endtask

    task automatic test_backpressure();
        set_req(0, FLT, 32'hBF800000, 32'h3F800000);
        set_req(1, FLT, 32'h3F800000, 32'hBF800000);
        resp_ready = 1'b0;
        req_valid  = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_accept: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_cmp1_ready: got %b expected 00", req_ready); end
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            checks++; if (resp_valid !== 1'b1 || resp_data !== 32'd1 || resp_id !== 1'b0) begin errors++; $display("FAIL bp_hold s=%0d: got valid=%b data=%h id=%h expected 1 00000001 0", s, resp_valid, resp_data, resp_id); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_stall_ready s=%0d: got %b expected 00", s, req_ready); end
            $display("stall %0d: resp_valid=%b resp_data=%h resp_id=%h req_ready=%b", s, resp_valid, resp_data, resp_id, req_ready);
        end
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_resume_accept: got %b expected 10", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_after_hs: got %b expected 0", resp_valid); end
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_data !== 32'd0) begin errors++; $display("FAIL bp_second_resp: got valid=%b id=%h data=%h expected 1 1 00000000", resp_valid, resp_id, resp_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        set_req(1, FEQ, 32'h3F800000, 32'h3F800000);
        req_valid = 2'b10; resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL mid_accept: got %b expected 10", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset: got valid=%b busy=%b expected 0 0", resp_valid, busy); end
        checks++; if (resp_id !== 1'b0) begin errors++; $display("FAIL mid_reset_id: got %h expected 0", resp_id); end
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_resp c=%0d: got %b expected 0", c, resp_valid); end
        end
        set_req(0, FLT, 32'hBF800000, 32'h3F800000);
        set_req(1, FLT, 32'h3F800000, 32'hBF800000);
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_first_grant: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== 32'd1) begin errors++; $display("FAIL mid_post_resp: got valid=%b id=%h data=%h expected 1 0 00000001", resp_valid, resp_id, resp_data); end
        @(posedge clk); #1;
        $display("test_reset_midflight done");
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_single_ops();
        test_backpressure();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
